instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader: the write side of the instruction memory, which the core itself only reads. It receives a little-endian byte stream (e.g. from a UART receiver), parses a 4-byte word count followed by the program image, and writes 32-bit words sequentially into instruction memory from byte address 0. It holds the core in reset until the image is fully written and one settling cycle has elapsed.

## Interface
Parameters:
- MEM_WORDS, default 4096: capacity in 32-bit words; a larger length is rejected.
- TIMEOUT_CYCLES, default 1_000_000: idle gap, in cycles, that aborts a partial frame.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  single-cycle strobe, rx_data_i valid; no backpressure.
- mem_we_o  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr_o  out  32  byte address of the write (word index × 4).
- mem_wdata_o  out  32  assembled word.
- core_rst_o  out  1  core reset, high until load completes.
- done_o  out  1  load complete, sticky until rst_i.
- error_o  out  1  length rejected, sticky until rst_i.
- words_loaded_o  out  32  count of words written so far.

## Operation
- States: S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERR. Reset state is S_LEN.
- S_LEN:
  - Collect 4 bytes into len_q, first byte into bits [7:0].
  - On the 4th byte, len_q > MEM_WORDS → S_ERR.
  - len_q == 0 → S_FLUSH.
  - Otherwise → S_DATA.
- S_DATA:
  - Collect bytes into a word, little-endian.
  - On each 4th byte, register a write at the next edge: mem_we_o=1, mem_addr_o=word_idx<<2, mem_wdata_o=word. Then word_idx and words_loaded_o increment.
  - When the written word is word len_q-1 → S_FLUSH.
- S_FLUSH: one cycle, then → S_DONE.
- S_DONE: done_o=1, core_rst_o=0. rx_valid_i is ignored.
- S_ERR: error_o=1, core_rst_o stays 1. rx_valid_i is ignored. Only rst_i exits.
- Timeout:
  - Counter clears on every accepted byte.
  - Counts while a frame is partial: byte_cnt≠0 in S_LEN, or any cycle in S_DATA.
  - On reaching TIMEOUT_CYCLES → S_LEN with byte_cnt, word_idx and words_loaded_o cleared.
  - Memory already written is not undone. No write is issued for a partial word.
- Arithmetic:
  - byte_cnt is 2 bits and wraps 3→0 on word completion.
  - word_idx is $clog2(MEM_WORDS)+1 bits.
  - mem_addr_o is zero-extended to 32 bits.
- Reset values: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=1, done_o=0, error_o=0, words_loaded_o=0.
- rst_i mid-load: all state is cleared immediately, core_rst_o=1, and the next byte is treated as length byte 0.

## Timing
- The 4th byte of a word is accepted at edge T. mem_we_o is high during T→T+1, for exactly one cycle.
- Back-to-back strobes on consecutive cycles are legal. Writes then occur every 4th cycle.
- The last write pulse is during T→T+1. S_FLUSH is T+1→T+2. done_o rises and core_rst_o falls at edge T+2.
- A length of 0 accepted at T gives done_o at T+2.
- error_o rises the edge after the 4th length byte.
- Timeout fires on the edge where the counter reaches TIMEOUT_CYCLES. A byte strobe on that same edge wins: it is accepted and the counter clears.

## Structure
- Package loader_pkg holds:
  - the state enum loader_state_t {S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERR};
  - BYTES_PER_WORD=4.
- Sub-module word_packer holds:
  - the byte_cnt register and 32-bit shift/assemble register;
  - a word_ready pulse output;
  - a clear input, used for timeout and state changes.
- The FSM, timeout counter and memory-write registers live in instr_loader.

## Test plan
- Bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 → writes (0x0,0x00000013) and (0x4,0x00100093). done_o is high 2 cycles after the second write pulse. words_loaded_o=2.
- Bytes 00 00 00 00 → no mem_we_o. done_o=1 and core_rst_o=0 two cycles after the 4th byte.
- Length 0x00001001 with MEM_WORDS=4096 → error_o=1 the next cycle. core_rst_o stays 1. Further bytes produce no writes.
- Length 1, then 2 payload bytes, then a gap of TIMEOUT_CYCLES (set to 16) → no write. Then a fresh frame 01 00 00 00 | EF BE AD DE writes 0xDEADBEEF at 0x0.
- rst_i asserted between payload bytes 2 and 3 → outputs reach reset values without a clock edge. A full reload after release succeeds.
- All bytes strobed on consecutive cycles, length 3 → exactly 3 write pulses, 4 cycles apart, at addresses 0x0, 0x4, 0x8.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the loader FSM state encoding and the byte/word geometry.
// Imported by instr_loader and word_packer.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Latency: word_rdy_o is combinational with the 4th byte's strobe.
// No backpressure: every strobe is consumed unless clear_i is high.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        word_rdy_o,
  output logic [31:0] word_dat_o,
  output logic [1:0]  byte_cnt_o
);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_shift;

  // Shift each byte in from the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
    end else if (clear_i) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
    end else if (byte_vld_i) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= {byte_dat_i, r_shift[31:8]};
    end
  end

  // The completed word includes the byte arriving this cycle.
  assign word_rdy_o = byte_vld_i && !clear_i && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word_dat_o = {byte_dat_i, r_shift[31:8]};
  assign byte_cnt_o = r_byte_cnt;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a 4-byte word count plus image, writes words to instruction memory.
// Latency: write pulse the edge the 4th byte of a word is taken; done two edges after the last write.
// No backpressure: bytes arriving in S_FLUSH/S_DONE/S_ERR are dropped.
module instr_loader
  import loader_pkg::*;
#(
  parameter int MEM_WORDS      = 4096,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] words_loaded_o
);

  localparam int IDX_W = $clog2(MEM_WORDS) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t    r_state;
  loader_state_t    w_next;
  logic [31:0]      r_len;
  logic             r_len_vld;
  logic [IDX_W-1:0] r_word_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_words;

  logic             w_accept;
  logic             w_counting;
  logic             w_timeout;
  logic             w_clear;
  logic             w_len_ok;
  logic             w_data_end;
  logic             w_word_rdy;
  logic [31:0]      w_word;
  logic [1:0]       w_byte_cnt;
  logic             w_wr;
  logic             w_len_done;

  word_packer u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (w_clear),
    .byte_vld_i (w_accept),
    .byte_dat_i (rx_data_i),
    .word_rdy_o (w_word_rdy),
    .word_dat_o (w_word),
    .byte_cnt_o (w_byte_cnt)
  );

  // The length is judged one edge after it arrives; a good length lets the next byte in at once.
  assign w_len_ok   = (r_len != 32'd0) && (r_len <= 32'(MEM_WORDS));
  assign w_data_end = (r_state == S_DATA) && (32'(r_word_idx) == r_len);
  assign w_timeout  = w_counting && !w_accept && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_wr       = w_accept && w_word_rdy && (r_state == S_DATA);
  assign w_len_done = w_accept && w_word_rdy && (r_state == S_LEN);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_LEN;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN: begin
        if (r_len_vld) begin
          if (r_len > 32'(MEM_WORDS)) w_next = S_ERR;
          else if (r_len == 32'd0)    w_next = S_FLUSH;
          else                        w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_data_end)     w_next = S_FLUSH;
        else if (w_timeout) w_next = S_LEN;
      end
      S_FLUSH: w_next = S_DONE;
      default: w_next = r_state;
    endcase
  end

  // Per-state byte acceptance, timeout arming and status outputs.
  always_comb begin
    w_accept   = 1'b0;
    w_counting = 1'b0;
    w_clear    = 1'b0;
    core_rst_o = 1'b1;
    done_o     = 1'b0;
    error_o    = 1'b0;
    case (r_state)
      S_LEN: begin
        w_accept   = rx_valid_i && (!r_len_vld || w_len_ok);
        w_counting = (w_byte_cnt != 2'd0);
      end
      S_DATA: begin
        w_accept   = rx_valid_i && !w_data_end;
        w_counting = 1'b1;
      end
      S_DONE: begin
        w_clear    = 1'b1;
        core_rst_o = 1'b0;
        done_o     = 1'b1;
      end
      S_ERR: begin
        w_clear = 1'b1;
        error_o = 1'b1;
      end
      default: ;
    endcase
    if (w_timeout) w_clear = 1'b1;
  end

  // Write registers, word index, captured length and idle-gap counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_words    <= 32'd0;
      r_word_idx <= '0;
      r_len      <= 32'd0;
      r_len_vld  <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_we      <= w_wr;
      r_len_vld <= w_len_done;
      if (w_len_done) r_len <= w_word;
      if (w_wr) begin
        r_addr     <= 32'(r_word_idx) << 2;
        r_wdata    <= w_word;
        r_word_idx <= r_word_idx + IDX_W'(1);
        r_words    <= r_words + 32'd1;
      end
      if (w_timeout) begin
        r_word_idx <= '0;
        r_words    <= 32'd0;
      end
      if (w_accept || !w_counting || w_timeout) r_to_cnt <= '0;
      else                                       r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign mem_we_o       = r_we;
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign words_loaded_o = r_words;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: frame parsing, length bounds, timeout, reset, streaming.
// Writes are captured at the falling edge with the cycle they appeared in.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;
  logic [31:0] words_loaded;

  instr_loader #(.MEM_WORDS(4096), .TIMEOUT_CYCLES(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .core_rst_o     (core_rst),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  // Record every write pulse with the cycle it was visible in.
  always @(negedge clk) begin
    if (mem_we) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
      q_cyc.push_back(cyc);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int t_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    check(tag, 32'(q_addr.size() > idx), 32'd1);
    if (q_addr.size() > idx) begin
      check(tag, q_addr[idx], a);
      check(tag, q_data[idx], d);
    end
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", words_loaded, 32'd0);

    // Two-word image with gaps between words.
    send_word(32'd2);
    idle(3);
    send_word(32'h0000_0013);
    idle(3);
    send_word(32'h0010_0093);
    t_last = cyc;
    idle(1);
    check("t1_done_early", 32'(done), 32'd0);
    check("t1_core_rst_early", 32'(core_rst), 32'd1);
    idle(1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_core_rst", 32'(core_rst), 32'd0);
    check("t1_words", words_loaded, 32'd2);
    check("t1_nwr", 32'(q_addr.size()), 32'd2);
    check_wr("t1_wr0", 0, 32'h0, 32'h0000_0013);
    check_wr("t1_wr1", 1, 32'h4, 32'h0010_0093);
    if (q_cyc.size() == 2) check("t1_wr1_cycle", 32'(q_cyc[1]), 32'(t_last));
    send_word(32'h1234_5678);
    idle(2);
    check("t1_ignored_after_done", 32'(q_addr.size()), 32'd2);

    // Zero-length image.
    do_reset();
    send_word(32'd0);
    idle(1);
    check("t2_done_early", 32'(done), 32'd0);
    idle(1);
    check("t2_done", 32'(done), 32'd1);
    check("t2_core_rst", 32'(core_rst), 32'd0);
    check("t2_nwr", 32'(q_addr.size()), 32'd0);

    // Oversized length is rejected and sticks.
    do_reset();
    send_word(32'h0000_1001);
    idle(1);
    check("t3_error", 32'(error), 32'd1);
    check("t3_core_rst", 32'(core_rst), 32'd1);
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    idle(2);
    check("t3_nwr", 32'(q_addr.size()), 32'd0);
    check("t3_error_sticky", 32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);

    // Length equal to capacity is accepted.
    do_reset();
    send_word(32'h0000_1000);
    idle(2);
    check("t3b_no_error", 32'(error), 32'd0);
    send_word(32'hCAFE_F00D);
    idle(1);
    check_wr("t3b_wr0", 0, 32'h0, 32'hCAFE_F00D);
    check("t3b_core_rst", 32'(core_rst), 32'd1);

    // Byte arriving on the exact timeout edge is still taken.
    do_reset();
    send_word(32'd1);
    send(8'hAA);
    send(8'hBB);
    idle(15);
    send(8'hCC);
    send(8'hDD);
    idle(3);
    check("t4a_nwr", 32'(q_addr.size()), 32'd1);
    check_wr("t4a_wr0", 0, 32'h0, 32'hDDCC_BBAA);
    check("t4a_done", 32'(done), 32'd1);

    // Full idle gap aborts the partial frame; a fresh frame restarts at address 0.
    do_reset();
    send_word(32'd2);
    send_word(32'h4433_2211);
    send(8'h55);
    send(8'h66);
    check("t4b_words_before", words_loaded, 32'd1);
    idle(16);
    check("t4b_words_cleared", words_loaded, 32'd0);
    check("t4b_nwr_partial", 32'(q_addr.size()), 32'd1);
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    idle(3);
    check("t4b_nwr", 32'(q_addr.size()), 32'd2);
    check_wr("t4b_wr1", 1, 32'h0, 32'hDEAD_BEEF);
    check("t4b_done", 32'(done), 32'd1);
    check("t4b_words", words_loaded, 32'd1);

    // Asynchronous reset in the middle of a word.
    do_reset();
    send_word(32'd3);
    send_word(32'h7856_3412);
    send(8'h9A);
    send(8'hBC);
    idle(1);
    check("t5_words_before", words_loaded, 32'd1);
    check("t5_wdata_before", mem_wdata, 32'h7856_3412);
    rst = 1'b1;
    #1;
    check("t5_we", 32'(mem_we), 32'd0);
    check("t5_addr", mem_addr, 32'd0);
    check("t5_wdata", mem_wdata, 32'd0);
    check("t5_core_rst", 32'(core_rst), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_error", 32'(error), 32'd0);
    check("t5_words", words_loaded, 32'd0);
    idle(1);
    rst = 1'b0;
    clear_q();
    send_word(32'd1);
    send_word(32'h0403_0201);
    idle(3);
    check("t5_nwr", 32'(q_addr.size()), 32'd1);
    check_wr("t5_wr0", 0, 32'h0, 32'h0403_0201);
    check("t5_reload_done", 32'(done), 32'd1);

    // Back-to-back stream, three words.
    do_reset();
    send_word(32'd3);
    send_word(32'h0302_0100);
    send_word(32'h0706_0504);
    send_word(32'h0B0A_0908);
    t_last = cyc;
    idle(1);
    check("t6_done_early", 32'(done), 32'd0);
    idle(1);
    check("t6_done", 32'(done), 32'd1);
    check("t6_nwr", 32'(q_addr.size()), 32'd3);
    check_wr("t6_wr0", 0, 32'h0, 32'h0302_0100);
    check_wr("t6_wr1", 1, 32'h4, 32'h0706_0504);
    check_wr("t6_wr2", 2, 32'h8, 32'h0B0A_0908);
    if (q_cyc.size() == 3) begin
      check("t6_gap01", 32'(q_cyc[1] - q_cyc[0]), 32'd4);
      check("t6_gap12", 32'(q_cyc[2] - q_cyc[1]), 32'd4);
      check("t6_last_cycle", 32'(q_cyc[2]), 32'(t_last));
    end
    check("t6_words", words_loaded, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
